dmem_responder: RTL and testbench

//  Memory-side responder for the pipeline's MEM-stage data accesses (lw/sw).

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 94 +++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data responder.
package dmem_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t WAIT = 2'd1;
   localparam state_t RESP = 2'd2;

   localparam int WORD_BYTES = 4;

   // Upper address bits fall away so the storage aliases every DEPTH*WORD_BYTES bytes.
   function automatic logic [31:0] word_index(input logic [31:0] addr, input int depth);
      return (addr >> $clog2(WORD_BYTES)) & 32'(depth - 1);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, registered read, no reset.
// Contents deliberately survive reset so a mid-run reset does not lose data.
module dmem_array #(
   parameter  int DEPTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          wr_en,
   input  logic          rd_en,
   input  logic [AW-1:0] word_idx,
   input  logic [31:0]   wr_dat,
   output logic [31:0]   rd_dat
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[word_idx] <= wr_dat;
      if (rd_en) rd_dat <= mem[word_idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: one access at a time, LATENCY wait cycles, then a one-cycle response.
// req_ready_o is low from accept through the response; stall_o freezes the pipeline until then.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 32,
   parameter int LATENCY = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        req_ready_o,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic        stall_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          wr_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic          rd_sel;
   logic [31:0]   arr_rd_dat;
   logic          misaligned;
   logic          done;
   logic          wr_en;
   logic          rd_en;
   logic [AW-1:0] word_idx;

   assign misaligned = (addr_q[1:0] != 2'b00);
   assign done       = (state == WAIT) && (cnt == '0);
   assign wr_en      = done && wr_q && !misaligned;
   assign rd_en      = done && !wr_q && !misaligned;
   assign word_idx   = AW'(word_index(addr_q, DEPTH));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         cnt        <= '0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         resp_err_o <= 1'b0;
         rd_sel     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  wr_q    <= req_write_i;
                  addr_q  <= req_addr_i;
                  wdata_q <= req_wdata_i;
                  cnt     <= CW'(LATENCY - 1);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state      <= RESP;
                  resp_err_o <= misaligned;
                  // Only an aligned load exposes array data; stores and errors return zero.
                  rd_sel     <= rd_en;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk_i    (clk_i),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .word_idx (word_idx),
      .wr_dat   (wdata_q),
      .rd_dat   (arr_rd_dat)
   );

   assign req_ready_o  = (state == IDLE);
   assign resp_valid_o = (state == RESP);
   assign resp_rdata_o = rd_sel ? arr_rd_dat : 32'd0;
   assign stall_o      = ((state == IDLE) && req_valid_i) || (state == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 4 and 1) each shadowed by a transaction-level
// model checked every cycle, plus directed transactions with hand-computed expectations.
module tb_dmem_responder;

   localparam int DEPTH = 32;

   logic        clk_i;
   logic        rst_i;
   logic [1:0]  vld;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  rdy;
   logic [1:0]  rv;
   logic [1:0]  err;
   logic [1:0]  stall;
   logic [31:0] rdata [2];

   int n_cmp = 0;
   int n_bad = 0;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 4 : 1;

      dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .req_valid_i  (vld[g]),
         .req_write_i  (wr),
         .req_addr_i   (addr),
         .req_wdata_i  (wdata),
         .req_ready_o  (rdy[g]),
         .resp_valid_o (rv[g]),
         .resp_rdata_o (rdata[g]),
         .resp_err_o   (err[g]),
         .stall_o      (stall[g])
      );

      // Model: k counts edges since accept; cycles k<LAT are waiting, k==LAT is the response.
      logic [31:0] mem [DEPTH];
      bit          known [DEPTH];
      bit          busy, rd_known, m_wr;
      int          k, idx;
      logic [31:0] m_addr, m_wdata, e_rdata;
      logic        e_err;

      initial begin
         busy = 0; k = 0; rd_known = 1; e_rdata = '0; e_err = 1'b0;
         m_wr = 0; m_addr = '0; m_wdata = '0; idx = 0;
         for (int i = 0; i < DEPTH; i++) known[i] = 0;
         forever begin
            @(posedge clk_i);
            if (rst_i) begin
               busy = 0; k = 0; e_rdata = '0; e_err = 1'b0; rd_known = 1;
            end else if (busy) begin
               k++;
               if (k == LAT) begin
                  idx = int'((m_addr / 32'd4) % DEPTH);
                  if (m_addr % 4 != 0) begin
                     e_err = 1'b1; e_rdata = '0; rd_known = 1;
                  end else if (m_wr) begin
                     mem[idx] = m_wdata; known[idx] = 1;
                     e_err = 1'b0; e_rdata = '0; rd_known = 1;
                  end else begin
                     e_err = 1'b0; e_rdata = mem[idx]; rd_known = known[idx];
                  end
               end else if (k == LAT + 1) begin
                  busy = 0;
               end
            end else if (vld[g]) begin
               busy = 1; k = 0; m_wr = wr; m_addr = addr; m_wdata = wdata;
            end
            #1;
            check($sformatf("u%0d.req_ready", g), rdy[g], !busy);
            check($sformatf("u%0d.resp_valid", g), rv[g], busy && k == LAT);
            check($sformatf("u%0d.stall", g), stall[g], (!busy && vld[g]) || (busy && k < LAT));
            check($sformatf("u%0d.resp_err", g), err[g], e_err);
            if (rd_known) check($sformatf("u%0d.resp_rdata", g), rdata[g], e_rdata);
         end
      end
   end

   // One complete transaction on instance i; reports stall cycles, accept-to-response cycles and result.
   task automatic txn(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output int n_stall, output int lat, output logic [31:0] rd, output bit er);
      int ca;
      bit got;
      ca = -1; got = 0; n_stall = 0; lat = -1; rd = '0; er = 0;
      @(negedge clk_i);
      wr = w; addr = a; wdata = d; vld[i] = 1'b1;
      for (int c = 0; c < 40 && !got; c++) begin
         #1;
         if (stall[i]) n_stall++;
         if (rv[i]) begin
            got = 1; lat = c - ca; rd = rdata[i]; er = err[i];
         end
         if (ca < 0 && vld[i] && rdy[i]) ca = c;
         @(negedge clk_i);
         if (ca >= 0) vld[i] = 1'b0;
      end
      vld[i] = 1'b0;
      check("txn_completed", got, 1);
   endtask

   initial begin
      int          ns, lat, ok, nrv;
      logic [31:0] rd;
      bit          er;
      int          acc [$];

      rst_i = 1'b1; vld = '0; wr = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;

      // Reset pulse then a quiet interval.
      @(negedge clk_i); rst_i = 1'b1;
      @(negedge clk_i); rst_i = 1'b0;
      ok = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i); #1;
         if (rdy[0] && !stall[0] && !rv[0]) ok++;
      end
      check("idle_20_cycles", ok, 20);

      // Store, then loads of the same word directly and through the address alias.
      txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, ns, lat, rd, er);
      check("st_stall_cycles", ns, 5);
      check("st_latency", lat, 5);
      check("st_err", er, 0);
      check("st_rdata", rd, 32'h0);
      txn(0, 1'b0, 32'h0000_0010, 32'h0, ns, lat, rd, er);
      check("ld_rdata", rd, 32'hDEAD_BEEF);
      check("ld_latency", lat, 5);
      txn(0, 1'b0, 32'h0000_0090, 32'h0, ns, lat, rd, er);
      check("ld_wrap_rdata", rd, 32'hDEAD_BEEF);

      // Misaligned store is rejected and leaves the word alone.
      txn(0, 1'b1, 32'h0000_0013, 32'h5555_5555, ns, lat, rd, er);
      check("mis_err", er, 1);
      check("mis_rdata", rd, 32'h0);
      check("mis_latency", lat, 5);
      txn(0, 1'b0, 32'h0000_0010, 32'h0, ns, lat, rd, er);
      check("mis_word_kept", rd, 32'hDEAD_BEEF);
      check("mis_cleared_err", er, 0);

      // Store aborted by reset while waiting: no response, array unchanged.
      txn(0, 1'b1, 32'h0000_0008, 32'hA5A5_0008, ns, lat, rd, er);
      @(negedge clk_i);
      wr = 1'b1; addr = 32'h0000_0008; wdata = 32'h1234_5678; vld[0] = 1'b1;
      #1; check("ab_ready_at_accept", rdy[0], 1);
      @(negedge clk_i); vld[0] = 1'b0;
      @(negedge clk_i); rst_i = 1'b1;
      #1;
      check("ab_ready_in_reset", rdy[0], 1);
      check("ab_stall_in_reset", stall[0], 0);
      @(negedge clk_i); rst_i = 1'b0;
      nrv = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_i); #1;
         if (rv[0]) nrv++;
      end
      check("ab_no_resp", nrv, 0);
      txn(0, 1'b0, 32'h0000_0008, 32'h0, ns, lat, rd, er);
      check("ab_prior_contents", rd, 32'hA5A5_0008);

      // LATENCY=1 instance with valid held for three requests.
      @(negedge clk_i);
      wr = 1'b1; addr = 32'h0000_0020; wdata = 32'hCAFE_0001; vld[1] = 1'b1;
      nrv = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (vld[1] && rdy[1]) acc.push_back(c);
         if (rv[1]) nrv++;
         if (vld[1]) check("lat1_stall_vs_resp", stall[1], !rv[1]);
         @(negedge clk_i);
         if (c == 6) vld[1] = 1'b0;
      end
      check("lat1_accept_count", acc.size(), 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("lat1_accept%0d_cycle", i), (acc.size() > i) ? acc[i] : -1, 3 * i);
      check("lat1_resp_count", nrv, 3);

      // Random traffic on both instances, with one reset mid-stream.
      for (int c = 0; c < 600; c++) begin
         @(negedge clk_i);
         vld   = 2'($urandom_range(0, 3));
         wr    = 1'($urandom_range(0, 1));
         addr  = ($urandom & 32'hFFFF_FF80) | (32'($urandom_range(0, 7)) << 2)
               | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
         wdata = $urandom;
         rst_i = (c == 300);
      end
      @(negedge clk_i);
      vld = '0; rst_i = 1'b0;
      repeat (10) @(negedge clk_i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

endmodule
